// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the adder post-processing blocks.
package adder_pkg;

   localparam int BITWIDTH_DEF = 8;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_e;

   // Accumulator width: one sample plus enough headroom for a full window.
   function automatic int acc_w(input int bitwidth, input int window);
      return bitwidth + 1 + $clog2(window);
   endfunction

endpackage

// File: rtl/adder_acc_if.sv
// Sample input and result output handshake of the windowed accumulator.
interface adder_acc_if
   import adder_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEF,
   parameter int WINDOW   = 16
);
   localparam int ACCW = acc_w(BITWIDTH, WINDOW);

   logic            iEn;
   logic            iClr;
   logic            iValid;
   logic [BITWIDTH:0] iData;
   logic            oReady;
   logic            iReady;
   logic            oValid;
   logic [ACCW-1:0] oData;
   logic [BITWIDTH:0] oMean;

   modport master (
      output iEn, iClr, iValid, iData, iReady,
      input  oReady, oValid, oData, oMean
   );

   modport slave (
      input  iEn, iClr, iValid, iData, iReady,
      output oReady, oValid, oData, oMean
   );

endinterface

// File: rtl/adder_acc_win_counter.sv
// Sample counter for one window; oLast flags the final sample slot.
module win_counter #(
   parameter int WINDOW = 16
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iEn,
   input  logic iClr,
   output logic oLast
);
   localparam int CW = $clog2(WINDOW);

   logic [CW-1:0] cnt;

   // WINDOW is a power of two, so the natural wrap returns to zero after the last slot.
   always_ff @(posedge iClk) begin
      if (iRst || iClr) begin
         cnt <= '0;
      end else if (iEn) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign oLast = (cnt == CW'(WINDOW - 1));

endmodule

// File: rtl/adder_acc.sv
// Windowed accumulator: sums WINDOW accepted samples and holds sum and mean until taken.
module adder_acc
   import adder_pkg::*;
#(
   parameter int BITWIDTH = BITWIDTH_DEF,
   parameter int WINDOW   = 16
) (
   input  logic       iClk,
   input  logic       iRst,
   adder_acc_if.slave bus
);
   localparam int ACCW = acc_w(BITWIDTH, WINDOW);
   localparam int LOGW = $clog2(WINDOW);

   if ((WINDOW < 2) || ((WINDOW & (WINDOW - 1)) != 0)) begin : g_window_check
      $error("adder_acc: WINDOW must be a power of two and >= 2");
   end

   // Mean is a plain truncating shift; the window sum always fits the sample width afterwards.
   function automatic logic [BITWIDTH:0] win_mean(input logic [ACCW-1:0] sum);
      logic [ACCW-1:0] shifted;
      shifted = sum >> LOGW;
      return shifted[BITWIDTH:0];
   endfunction

   acc_state_e        state;
   logic [ACCW-1:0]   acc;
   logic [ACCW-1:0]   sum_next;
   logic [ACCW-1:0]   data_q;
   logic [BITWIDTH:0] mean_q;
   logic              valid_q;
   logic              ready;
   logic              accept;
   logic              last;

   assign ready    = (state == ACC) && bus.iEn && !bus.iClr;
   assign accept   = bus.iValid && ready;
   assign sum_next = acc + ACCW'(bus.iData);

   win_counter #(
      .WINDOW (WINDOW)
   ) u_win_counter (
      .iClk  (iClk),
      .iRst  (iRst),
      .iEn   (accept),
      .iClr  (bus.iClr),
      .oLast (last)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state   <= ACC;
         acc     <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         mean_q  <= '0;
      end else if (bus.iClr) begin
         // Clear discards the window and any pending result but keeps the last outputs visible.
         state   <= ACC;
         acc     <= '0;
         valid_q <= 1'b0;
      end else if (bus.iEn) begin
         case (state)
            ACC: begin
               if (accept) begin
                  if (last) begin
                     data_q  <= sum_next;
                     mean_q  <= win_mean(sum_next);
                     acc     <= '0;
                     valid_q <= 1'b1;
                     state   <= HOLD;
                  end else begin
                     acc <= sum_next;
                  end
               end
            end
            HOLD: begin
               if (bus.iReady && valid_q) begin
                  valid_q <= 1'b0;
                  state   <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

   assign bus.oReady = ready;
   assign bus.oValid = valid_q;
   assign bus.oData  = data_q;
   assign bus.oMean  = mean_q;

endmodule

// File: tb/tb_adder_acc.sv
// Directed bench for adder_acc with a result scoreboard (BITWIDTH=8, WINDOW=4).
module tb_adder_acc;
   localparam int BW  = 8;
   localparam int WIN = 4;

   typedef struct {
      logic [31:0] data;
      logic [31:0] mean;
   } result_t;

   logic clk;
   logic rst;

   adder_acc_if #(.BITWIDTH(BW), .WINDOW(WIN)) bus ();

   adder_acc #(.BITWIDTH(BW), .WINDOW(WIN)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   result_t exp_q[$];
   result_t cur;
   int      checks = 0;
   int      errors = 0;
   int      m_sum  = 0;
   int      m_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_sum = 0;
      m_cnt = 0;
   endtask

   // Present one sample for a single cycle; it must be accepted.
   task automatic send(input int v);
      result_t r;
      bus.iValid = 1'b1;
      bus.iData  = v[BW:0];
      #1;
      chk("ready_in_acc", bus.oReady, 1);
      tick();
      bus.iValid = 1'b0;
      m_sum += v;
      m_cnt++;
      if (m_cnt == WIN) begin
         r.data = m_sum;
         r.mean = m_sum >> 2;
         exp_q.push_back(r);
         model_clear();
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.oValid && n < 20) begin
         tick();
         n++;
      end
      chk("valid_rise", bus.oValid, 1);
   endtask

   task automatic pop_check();
      chk("scoreboard_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         chk("sum", bus.oData, cur.data);
         chk("mean", bus.oMean, cur.mean);
      end
   endtask

   // Result must hold for 'hold' cycles of backpressure, then transfer.
   task automatic expect_result(input int hold);
      wait_valid();
      pop_check();
      chk("ready_in_hold", bus.oReady, 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", bus.oValid, 1);
         chk("hold_sum", bus.oData, cur.data);
         chk("hold_ready", bus.oReady, 0);
      end
      bus.iReady = 1'b1;
      tick();
      chk("valid_after_xfer", bus.oValid, 0);
      chk("ready_after_xfer", bus.oReady, 1);
   endtask

   initial begin
      rst        = 1'b1;
      bus.iEn    = 1'b1;
      bus.iClr   = 1'b0;
      bus.iValid = 1'b0;
      bus.iData  = '0;
      bus.iReady = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_valid", bus.oValid, 0);
      chk("rst_data", bus.oData, 0);
      chk("rst_mean", bus.oMean, 0);
      chk("rst_ready", bus.oReady, 1);

      // Basic back-to-back window
      for (int i = 0; i < 4; i++) send(30);
      expect_result(0);

      // Mixed values with two-cycle gaps
      send(10); repeat (2) tick();
      send(20); repeat (2) tick();
      send(30); repeat (2) tick();
      send(45);
      expect_result(0);

      // Full-scale samples
      for (int i = 0; i < 4; i++) send(511);
      expect_result(0);

      // Backpressure for six cycles
      bus.iReady = 1'b0;
      send(1); send(2); send(3); send(4);
      expect_result(6);

      // Clear mid-window
      send(100); send(100);
      bus.iClr = 1'b1;
      #1;
      chk("ready_during_clr", bus.oReady, 0);
      tick();
      bus.iClr = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) send(10);
      expect_result(0);

      // Clear while a result is held
      bus.iReady = 1'b0;
      for (int i = 0; i < 4; i++) send(1);
      wait_valid();
      pop_check();
      bus.iClr = 1'b1;
      tick();
      bus.iClr = 1'b0;
      chk("clr_hold_valid", bus.oValid, 0);
      chk("clr_keeps_sum", bus.oData, 4);
      chk("clr_keeps_mean", bus.oMean, 1);
      #1;
      chk("clr_hold_ready", bus.oReady, 1);
      bus.iReady = 1'b1;

      // Clear coinciding with the last sample drops it
      send(8); send(8); send(8);
      bus.iValid = 1'b1;
      bus.iData  = 9'd8;
      bus.iClr   = 1'b1;
      #1;
      chk("clr_last_ready", bus.oReady, 0);
      tick();
      bus.iClr   = 1'b0;
      bus.iValid = 1'b0;
      model_clear();
      chk("clr_last_valid", bus.oValid, 0);
      for (int i = 0; i < 4; i++) send(7);
      expect_result(0);

      // Enable low mid-window freezes state
      send(5); send(5);
      bus.iEn    = 1'b0;
      bus.iValid = 1'b1;
      bus.iData  = 9'd99;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("en_low_ready", bus.oReady, 0);
         tick();
      end
      bus.iEn    = 1'b1;
      bus.iValid = 1'b0;
      send(5); send(5);
      expect_result(0);

      // Enable low in HOLD blocks the transfer
      bus.iReady = 1'b0;
      for (int i = 0; i < 4; i++) send(2);
      wait_valid();
      pop_check();
      bus.iEn    = 1'b0;
      bus.iReady = 1'b1;
      tick();
      tick();
      chk("en_low_hold_valid", bus.oValid, 1);
      chk("en_low_hold_sum", bus.oData, 8);
      bus.iEn = 1'b1;
      tick();
      chk("en_high_xfer", bus.oValid, 0);

      // Reset in HOLD
      bus.iReady = 1'b0;
      for (int i = 0; i < 4; i++) send(5);
      wait_valid();
      pop_check();
      bus.iReady = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      chk("rst_hold_valid", bus.oValid, 0);
      chk("rst_hold_data", bus.oData, 0);
      chk("rst_hold_mean", bus.oMean, 0);
      chk("rst_hold_ready", bus.oReady, 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
